// File: rtl/dcache_wt.sv
// ---------------------------------------------------------------------------
// dcache_wt
// Direct-mapped, write-through, no-write-allocate data cache that sits
// between the MIPS core's M stage and a slower word-wide main memory.
// Each of the 2**INDEX_BITS lines holds a valid bit, a tag and one data word.
//
// Ports
//   clk, reset   : clock and synchronous active-high reset
//   MemReadM     : load in M stage
//   MemWriteM    : store in M stage (wins over MemReadM)
//   AluOutM      : byte address, low two bits ignored
//   WriteDataM   : store data
//   ReadDataM    : load data (hit cycle or DONE cycle)
//   StallM       : combinational pipeline freeze
//   MemReq/MemWe : memory request valid / write enable (registered)
//   MemAddr      : word-aligned request address (registered)
//   MemWData     : request write data (registered)
//   MemRData     : memory read data, valid with MemReady
//   MemReady     : memory completes the current request this cycle
//   HitCount     : number of load hits, wraps
//   MissCount    : number of load misses, wraps
// ---------------------------------------------------------------------------
module dcache_wt #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] AluOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemReady,
    output logic [31:0] HitCount,
    output logic [31:0] MissCount
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        IDLE,
        RDMISS,
        WRITE,
        DONE
    } stateType;

    stateType state;

    logic [LINES-1:0]    validBits;
    logic [TAG_BITS-1:0] tagArray  [LINES];
    logic [31:0]         dataArray [LINES];

    logic [31:0]           reqAddr;
    logic [31:0]           reqData;
    logic [INDEX_BITS-1:0] lookupIdx;
    logic [TAG_BITS-1:0]   lookupTag;
    logic [INDEX_BITS-1:0] reqIdx;
    logic [TAG_BITS-1:0]   reqTag;
    logic                  lookupHit;
    logic                  reqHit;
    logic                  loadOnly;
    logic                  fillLine;
    logic                  updateLine;
    logic                  unusedByteOffset;

    // Accesses are whole words, so the byte offset never matters.
    assign unusedByteOffset = ^AluOutM[1:0];

    assign lookupIdx = AluOutM[INDEX_BITS+1:2];
    assign lookupTag = AluOutM[31:INDEX_BITS+2];
    assign reqIdx    = reqAddr[INDEX_BITS+1:2];
    assign reqTag    = reqAddr[31:INDEX_BITS+2];

    assign MemAddr  = reqAddr;
    assign MemWData = reqData;

    // Tag compare for the incoming core address and for the latched request
    // address. A store that arrives together with a load is treated purely
    // as a store, so loadOnly masks the load path in that case.
    always_comb begin
        lookupHit  = validBits[lookupIdx] && (tagArray[lookupIdx] == lookupTag);
        reqHit     = validBits[reqIdx] && (tagArray[reqIdx] == reqTag);
        loadOnly   = MemReadM && !MemWriteM;
        fillLine   = (state == RDMISS) && MemReady && !reset;
        updateLine = (state == WRITE) && MemReady && reqHit && !reset;
    end

    // Core-facing outputs. A load hit returns data in the same cycle with
    // no stall; a miss or store stalls from the decode cycle until memory
    // answers, and the DONE cycle releases the stall with the line data.
    always_comb begin
        StallM    = 1'b0;
        ReadDataM = 32'h0;
        case (state)
            IDLE: begin
                if (MemWriteM) begin
                    StallM = 1'b1;
                end else if (MemReadM) begin
                    if (lookupHit) begin
                        ReadDataM = dataArray[lookupIdx];
                    end else begin
                        StallM = 1'b1;
                    end
                end
            end
            RDMISS, WRITE: begin
                StallM = 1'b1;
            end
            DONE: begin
                ReadDataM = dataArray[reqIdx];
            end
            default: begin
                StallM = 1'b0;
            end
        endcase
    end

    // Main controller. Request registers drive the memory port directly so
    // MemReq/MemWe/MemAddr/MemWData stay stable while a request is pending.
    // Reset abandons any in-flight request and invalidates every line at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            validBits <= '0;
            MemReq    <= 1'b0;
            MemWe     <= 1'b0;
            reqAddr   <= 32'h0;
            reqData   <= 32'h0;
            HitCount  <= 32'h0;
            MissCount <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (MemWriteM) begin
                        reqAddr <= {AluOutM[31:2], 2'b00};
                        reqData <= WriteDataM;
                        MemReq  <= 1'b1;
                        MemWe   <= 1'b1;
                        state   <= WRITE;
                    end else if (loadOnly) begin
                        if (lookupHit) begin
                            HitCount <= HitCount + 32'd1;
                        end else begin
                            MissCount <= MissCount + 32'd1;
                            reqAddr   <= {AluOutM[31:2], 2'b00};
                            MemReq    <= 1'b1;
                            MemWe     <= 1'b0;
                            state     <= RDMISS;
                        end
                    end
                end
                RDMISS: begin
                    if (MemReady) begin
                        validBits[reqIdx] <= 1'b1;
                        MemReq            <= 1'b0;
                        state             <= DONE;
                    end
                end
                WRITE: begin
                    if (MemReady) begin
                        MemReq <= 1'b0;
                        MemWe  <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Line storage has no reset: only the valid bits need clearing. A refill
    // replaces whatever tag lived at the index; a store only touches the line
    // when it already holds the address (no write-allocate).
    always_ff @(posedge clk) begin
        if (fillLine) begin
            tagArray[reqIdx]  <= reqTag;
            dataArray[reqIdx] <= MemRData;
        end else if (updateLine) begin
            dataArray[reqIdx] <= reqData;
        end
    end

endmodule

// File: tb/tb_dcache_wt.sv
// ---------------------------------------------------------------------------
// tb_dcache_wt
// Directed self-checking bench for dcache_wt. A behavioural memory answers
// requests after a programmable number of cycles and keeps its own word
// store, so expected load data comes from the bench's memory contents.
// ---------------------------------------------------------------------------
module tb_dcache_wt;

    logic        clk;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] AluOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData;
    logic        MemReady;
    logic [31:0] HitCount;
    logic [31:0] MissCount;

    int checks;
    int errors;

    // Memory model state
    logic [31:0] memWords [logic [31:0]];
    int          memDelay;
    int          reqCycles;
    int          memReads;
    int          memWrites;
    logic        memAuto;
    logic        manualReady;

    // Observations from the last access
    int          obsStall;
    logic [31:0] obsData;
    logic        obsReq;
    logic        obsWe;
    logic [31:0] obsAddr;
    logic [31:0] obsWData;
    logic        obsReqInDone;

    dcache_wt #(.INDEX_BITS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .AluOutM    (AluOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MemReq     (MemReq),
        .MemWe      (MemWe),
        .MemAddr    (MemAddr),
        .MemWData   (MemWData),
        .MemRData   (MemRData),
        .MemReady   (MemReady),
        .HitCount   (HitCount),
        .MissCount  (MissCount)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] readWord(input logic [31:0] addr);
        if (memWords.exists(addr)) return memWords[addr];
        return ~addr;
    endfunction

    // Behavioural memory: counts cycles with MemReq high and answers on the
    // memDelay-th one. With memAuto cleared it only replays manualReady.
    always @(negedge clk) begin
        if (reset || !memAuto) begin
            reqCycles = 0;
            MemReady  = reset ? 1'b0 : manualReady;
        end else if (MemReq) begin
            reqCycles = reqCycles + 1;
            if (reqCycles == memDelay) begin
                MemReady = 1'b1;
                if (MemWe) begin
                    memWords[MemAddr] = MemWData;
                    memWrites = memWrites + 1;
                end else begin
                    MemRData = readWord(MemAddr);
                    memReads = memReads + 1;
                end
            end else begin
                MemReady = 1'b0;
            end
        end else begin
            reqCycles = 0;
            MemReady  = 1'b0;
        end
    end

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive core-side inputs on the falling edge.
    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        MemReadM   = rd;
        MemWriteM  = wr;
        AluOutM    = addr;
        WriteDataM = wdata;
    endtask

    // Run one core access: hold the inputs while StallM is high, record the
    // stall length, the first memory request seen and the released data.
    task automatic doAccess(input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata);
        obsStall = 0;
        obsReq   = 1'b0;
        obsWe    = 1'b0;
        obsAddr  = 32'h0;
        obsWData = 32'h0;
        applyStimulus(rd, wr, addr, wdata);
        #1;
        while (StallM && obsStall < 50) begin
            obsStall = obsStall + 1;
            if (MemReq && !obsReq) begin
                obsReq   = 1'b1;
                obsWe    = MemWe;
                obsAddr  = MemAddr;
                obsWData = MemWData;
            end
            @(negedge clk);
            #1;
        end
        obsData      = ReadDataM;
        obsReqInDone = MemReq;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
    endtask

    task automatic checkCounters(input string tag, input int expHit, input int expMiss);
        checkOutput({tag, " HitCount"}, HitCount, 32'(expHit));
        checkOutput({tag, " MissCount"}, MissCount, 32'(expMiss));
    endtask

    initial begin
        int readsBefore;
        int writesBefore;

        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        MemReadM    = 1'b0;
        MemWriteM   = 1'b0;
        AluOutM     = 32'h0;
        WriteDataM  = 32'h0;
        MemRData    = 32'h0;
        MemReady    = 1'b0;
        memDelay    = 3;
        reqCycles   = 0;
        memReads    = 0;
        memWrites   = 0;
        memAuto     = 1'b1;
        manualReady = 1'b0;
        memWords[32'h0000_0040] = 32'h1122_3344;
        memWords[32'h0000_0440] = 32'h5566_7788;
        memWords[32'h0000_0200] = 32'hA5A5_A5A5;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        $display("[TB] reset state");
        checkOutput("reset MemReq", {31'h0, MemReq}, 32'h0);
        checkOutput("reset MemWe", {31'h0, MemWe}, 32'h0);
        checkOutput("reset MemAddr", MemAddr, 32'h0);
        checkOutput("reset MemWData", MemWData, 32'h0);
        checkOutput("reset StallM", {31'h0, StallM}, 32'h0);
        checkOutput("reset ReadDataM", ReadDataM, 32'h0);
        checkCounters("reset", 0, 0);

        $display("[TB] cold load miss, 3-cycle memory");
        doAccess(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        checkOutput("cold stall", 32'(obsStall), 32'd4);
        checkOutput("cold data", obsData, 32'h1122_3344);
        checkOutput("cold MemWe", {31'h0, obsWe}, 32'h0);
        checkOutput("cold MemAddr", obsAddr, 32'h0000_0040);
        checkOutput("cold MemReq in DONE", {31'h0, obsReqInDone}, 32'h0);
        checkCounters("cold", 0, 1);

        $display("[TB] repeat load hits");
        readsBefore = memReads;
        doAccess(1'b1, 1'b0, 32'h0000_0043, 32'h0);
        checkOutput("hit stall", 32'(obsStall), 32'd0);
        checkOutput("hit data", obsData, 32'h1122_3344);
        checkOutput("hit mem reads", 32'(memReads - readsBefore), 32'd0);
        checkCounters("hit", 1, 1);

        $display("[TB] store hit, 1-cycle memory");
        memDelay = 1;
        writesBefore = memWrites;
        doAccess(1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
        checkOutput("store stall", 32'(obsStall), 32'd2);
        checkOutput("store MemReq", {31'h0, obsReq}, 32'h1);
        checkOutput("store MemWe", {31'h0, obsWe}, 32'h1);
        checkOutput("store MemAddr", obsAddr, 32'h0000_0040);
        checkOutput("store MemWData", obsWData, 32'hDEAD_BEEF);
        checkOutput("store mem writes", 32'(memWrites - writesBefore), 32'd1);
        checkCounters("store", 1, 1);

        readsBefore = memReads;
        doAccess(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        checkOutput("after store stall", 32'(obsStall), 32'd0);
        checkOutput("after store data", obsData, 32'hDEAD_BEEF);
        checkOutput("after store mem reads", 32'(memReads - readsBefore), 32'd0);
        checkCounters("after store", 2, 1);

        $display("[TB] store miss does not allocate");
        writesBefore = memWrites;
        doAccess(1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D);
        checkOutput("store miss stall", 32'(obsStall), 32'd2);
        checkOutput("store miss MemAddr", obsAddr, 32'h0000_0080);
        checkOutput("store miss mem writes", 32'(memWrites - writesBefore), 32'd1);
        doAccess(1'b1, 1'b0, 32'h0000_0080, 32'h0);
        checkOutput("load 0x80 stall", 32'(obsStall), 32'd2);
        checkOutput("load 0x80 data", obsData, 32'hCAFE_F00D);
        checkCounters("load 0x80", 2, 2);

        $display("[TB] index conflict 0x440 vs 0x40");
        doAccess(1'b1, 1'b0, 32'h0000_0440, 32'h0);
        checkOutput("conflict 0x440 stall", 32'(obsStall), 32'd2);
        checkOutput("conflict 0x440 data", obsData, 32'h5566_7788);
        doAccess(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        checkOutput("conflict 0x40 stall", 32'(obsStall), 32'd2);
        checkOutput("conflict 0x40 data", obsData, 32'hDEAD_BEEF);
        checkCounters("conflict", 2, 4);

        $display("[TB] read and write together");
        doAccess(1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678);
        checkOutput("rdwr stall", 32'(obsStall), 32'd2);
        checkOutput("rdwr MemWe", {31'h0, obsWe}, 32'h1);
        checkOutput("rdwr MemWData", obsWData, 32'h1234_5678);
        checkCounters("rdwr", 2, 4);
        doAccess(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        checkOutput("rdwr reload stall", 32'(obsStall), 32'd0);
        checkOutput("rdwr reload data", obsData, 32'h1234_5678);
        checkCounters("rdwr reload", 3, 4);

        $display("[TB] reset during a read miss");
        memAuto = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'h0);
        @(negedge clk);
        #1;
        checkOutput("midmiss MemReq", {31'h0, MemReq}, 32'h1);
        reset    = 1'b1;
        MemReadM = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midmiss reset MemReq", {31'h0, MemReq}, 32'h0);
        checkOutput("midmiss reset StallM", {31'h0, StallM}, 32'h0);
        checkCounters("midmiss reset", 0, 0);
        manualReady = 1'b1;
        MemRData    = 32'h9999_9999;
        @(negedge clk);
        manualReady = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("stray ready MemReq", {31'h0, MemReq}, 32'h0);
        memAuto = 1'b1;
        doAccess(1'b1, 1'b0, 32'h0000_0200, 32'h0);
        checkOutput("after reset 0x200 stall", 32'(obsStall), 32'd2);
        checkOutput("after reset 0x200 data", obsData, 32'hA5A5_A5A5);
        doAccess(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        checkOutput("after reset 0x40 stall", 32'(obsStall), 32'd2);
        checkCounters("after reset", 0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
